des_round_engine: RTL

Iterative 16-round DES Feistel core sitting between the initial permutation and the inverse initial permutation stage. Accepts the 64-bit IP output (L0||R0) and a 64-bit key, runs the internal key schedule (PC-1, per-round rotation, PC-2) and one round per clock through an external combinational f-function, and presents the pre-output block R16||L16 for the inverse permutation stage. Supports encryption and decryption with the same key.

---
 rtl/des_round_engine.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/des_round_engine.sv
// Iterative 16-round DES Feistel core with on-the-fly key schedule; f-function is external.
// Vectors are declared [N-1:0] with the MSB holding DES bit 1.
module des_round_engine (
  input  logic        i_clk,
  input  logic        i_set,
  input  logic        i_start,
  input  logic        i_decrypt,
  input  logic [63:0] i_data_in,
  input  logic [63:0] i_key_in,
  output logic [31:0] o_f_r,
  output logic [47:0] o_f_k,
  input  logic [31:0] i_f_out,
  output logic        o_busy,
  output logic        o_status,
  output logic [63:0] o_data_out
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // ROUND | one Feistel round per clock, 16 cycles
  // DONE  | result valid in o_data_out, start accepted again
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] p;
    p = '0;
    for (int i = 0; i < 56; i++) p[6'(55 - i)] = k[6'(64 - PC1[6'(i)])];
    return p;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] p;
    p = '0;
    for (int i = 0; i < 48; i++) p[6'(47 - i)] = cd[6'(56 - PC2[6'(i)])];
    return p;
  endfunction

  // Decrypt walks the schedule backwards, so it rotates right starting with 0.
  function automatic logic [27:0] rot(input logic [27:0] v, input logic dec, input logic [1:0] amt);
    case ({dec, amt})
      3'b001:  return {v[26:0], v[27]};
      3'b010:  return {v[25:0], v[27:26]};
      3'b101:  return {v[0], v[27:1]};
      3'b110:  return {v[1:0], v[27:2]};
      default: return v;
    endcase
  endfunction

  state_t      r_state, w_state_nxt;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic [3:0]  r_cnt;
  logic        r_dec;
  logic        r_status;
  logic [63:0] r_data_out;

  logic        w_accept, w_last;
  logic [1:0]  w_amt;
  logic [27:0] w_c_rot, w_d_rot;
  logic [31:0] w_r_new;

  always_comb begin
    w_amt = 2'd2;
    if (r_cnt == 4'd0) w_amt = r_dec ? 2'd0 : 2'd1;
    else if (r_cnt == 4'd1 || r_cnt == 4'd8 || r_cnt == 4'd15) w_amt = 2'd1;
  end

  assign w_c_rot = rot(r_c, r_dec, w_amt);
  assign w_d_rot = rot(r_d, r_dec, w_amt);
  assign w_r_new = r_l ^ i_f_out;

  assign o_f_r      = r_r;
  assign o_f_k      = pc2({w_c_rot, w_d_rot});
  assign o_status   = r_status;
  assign o_data_out = r_data_out;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        o_busy = 1'b1;
        if (r_cnt == 4'd15) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_set) begin
    if (i_set) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_set) begin
    if (i_set) begin
      r_l        <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_dec      <= 1'b0;
      r_status   <= 1'b0;
      r_data_out <= '0;
    end else if (w_accept) begin
      r_l        <= i_data_in[63:32];
      r_r        <= i_data_in[31:0];
      {r_c, r_d} <= pc1(i_key_in);
      r_dec      <= i_decrypt;
      r_cnt      <= '0;
      r_status   <= 1'b0;
    end else if (r_state == S_ROUND) begin
      r_l   <= r_r;
      r_r   <= w_r_new;
      r_c   <= w_c_rot;
      r_d   <= w_d_rot;
      r_cnt <= r_cnt + 4'd1;
      // No final swap: the inverse-IP stage expects R16||L16.
      if (w_last) begin
        r_data_out <= {w_r_new, r_r};
        r_status   <= 1'b1;
      end
    end
  end

endmodule
